// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch path.
//   fetch_state_t : fetch FSM encoding (IDLE / WAIT / KILL)
//   fetch_entry_t : one buffered fetch result {instr, pcplus4}
//   NOP_INSTR     : instruction word loaded into IF/ID on a bubble
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
//   imem_req    : request valid (master -> slave)
//   imem_addr   : request word address (master -> slave)
//   imem_ready  : request accepted when imem_req && imem_ready (slave -> master)
//   imem_rvalid : one-cycle, in-order response strobe (slave -> master)
//   imem_rdata  : response instruction word (slave -> master)
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer holding returned instructions until decode takes them.
//   clk, reset     : clock, asynchronous active-low reset
//   push, wdata    : write one entry (ignored when full unless popping too)
//   pop, rdata     : remove head entry; rdata always shows the head
//   clear          : drop all entries; wins over push and pop
//   full, empty    : occupancy flags
//   count          : current occupancy
import mips_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register of the pipelined MIPS core.
// Owns PCF, issues at most one outstanding instruction-memory request,
// buffers responses in fetch_fifo and presents them to decode.
//   clk, reset        : clock, asynchronous active-low reset
//   StallF            : hold PC, no new request
//   StallD            : hold IF/ID register
//   FlushD            : load bubble into IF/ID
//   PCSrcD, PCBranchD : taken branch/jump in decode and its target
//   imem              : instruction-memory bus (master side)
//   InstrD, PCPlus4D  : decode instruction and its PC+4
//   ValidD            : InstrD is a real instruction
// Optional (macro FETCH_PERF_EN):
//   BubbleCnt         : saturating count of empty-buffer bubbles
//   KillCnt           : saturating count of discarded responses
//
// state | meaning
// IDLE  | no request outstanding; may issue when buffer has room
// WAIT  | request accepted, response will be kept
// KILL  | request accepted before a redirect, response will be dropped
import mips_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         PCSrcD,
    input  logic [31:0]  PCBranchD,
    fetch_unit_if.master imem,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCPlus4D,
    output logic         ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  BubbleCnt,
    output logic [31:0]  KillCnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [31:0]      pcf;
    logic [31:0]      req_addr;
    logic             req_c;
    logic             accept;
    logic             redirect;
    logic             push;
    logic             pop;
    logic             discard;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign redirect = PCSrcD && !StallD;
    assign accept   = req_c && imem.imem_ready;

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pcf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        push      = 1'b0;
        discard   = 1'b0;
        case (state)
            IDLE: begin
                // A redirect cycle never issues: PCF is about to change.
                req_c = !StallF && (fifo_count < CNT_W'(BUF_DEPTH)) && !redirect;
                if (req_c && imem.imem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (redirect) begin
                        discard = 1'b1;
                    end else begin
                        push = !fifo_full || pop;
                    end
                    state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = KILL;
                end
            end
            KILL: begin
                if (imem.imem_rvalid) begin
                    discard   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcf      <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                pcf <= PCBranchD;
            end else if (accept) begin
                pcf <= pcf + 32'd4;
            end
            if (accept) begin
                req_addr <= pcf;
            end
        end
    end

    assign push_entry.instr   = imem.imem_rdata;
    assign push_entry.pcplus4 = req_addr + 32'd4;

    // Redirect empties the buffer, so nothing may leave it in that cycle either.
    assign pop = !StallD && !FlushD && !redirect && !fifo_empty;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (pop) begin
                InstrD   <= head.instr;
                PCPlus4D <= head.pcplus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCPlus4D <= 32'd0;
                ValidD   <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble_evt;

    // Only bubbles caused by starvation count; hazard flushes do not.
    assign bubble_evt = !StallD && !FlushD && fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BubbleCnt <= 32'd0;
            KillCnt   <= 32'd0;
        end else begin
            if (bubble_evt && (BubbleCnt != 32'hFFFF_FFFF)) begin
                BubbleCnt <= BubbleCnt + 32'd1;
            end
            if (discard && (KillCnt != 32'hFFFF_FFFF)) begin
                KillCnt <= KillCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a variable-latency imem responder, a monitor
// logging accepted addresses and real IF/ID loads, and one task per scenario.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] BubbleCnt;
    logic [31:0] KillCnt;
`endif

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .imem      (imem_bus),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .BubbleCnt (BubbleCnt),
        .KillCnt   (KillCnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    int          lat = 1;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic        acc_next = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    logic [31:0] paddr = 32'h0;
    logic        ld_edge = 1'b0;
    int unsigned cyc_n = 0;

    logic [31:0] acc_q[$];
    int unsigned acc_cyc_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_instr_q[$];
    int unsigned pop_cyc_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        acc_next = imem_bus.imem_req && imem_bus.imem_ready;
        if (acc_next) begin
            acc_addr = imem_bus.imem_addr;
            acc_q.push_back(acc_addr);
            acc_cyc_q.push_back(cyc_n);
        end
        if (ld_edge && ValidD) begin
            pop_pc_q.push_back(PCPlus4D);
            pop_instr_q.push_back(InstrD);
            pop_cyc_q.push_back(cyc_n);
        end
    end

    always @(posedge clk) begin
        cyc_n++;
        ld_edge = !StallD;
        #1;
        imem_bus.imem_rvalid = 1'b0;
        if (acc_next) begin
            pend     = 1'b1;
            cnt      = lat;
            paddr    = acc_addr;
            acc_next = 1'b0;
        end
        if (pend) begin
            if (cnt <= 1) begin
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = instr_of(paddr);
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        acc_cyc_q.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
        pop_cyc_q.delete();
    endtask

    task automatic do_reset();
        StallF = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b0;
        PCSrcD = 1'b0;
        PCBranchD = 32'h0;
        imem_bus.imem_ready = 1'b1;
        repeat (6) cyc();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", InstrD, 32'h0); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcplus4 got %h want %h", PCPlus4D, 32'h0); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ValidD); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want %h", imem_bus.imem_addr, 32'h0); end
`ifdef FETCH_PERF_EN
        checks++; if (BubbleCnt !== 32'h0) begin errors++; $display("FAIL reset_bubblecnt got %0d want 0", BubbleCnt); end
        checks++; if (KillCnt !== 32'h0) begin errors++; $display("FAIL reset_killcnt got %0d want 0", KillCnt); end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        lat = 1;
        StallF = 1'b0;
        cyc();
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL basic_valid_c1 got %b want 0", ValidD); end
        cyc();
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL basic_valid_c2 got %b want 0", ValidD); end
        cyc();
        checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL basic_valid_c3 got %b want 1", ValidD); end
        checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL basic_first_pc got %h want %h", PCPlus4D, 32'h4); end
        checks++; if (InstrD !== instr_of(32'h0)) begin errors++; $display("FAIL basic_first_instr got %h want %h", InstrD, instr_of(32'h0)); end
        repeat (8) cyc();
        checks++; if (pop_pc_q[1] !== 32'h8) begin errors++; $display("FAIL basic_pc2 got %h want %h", pop_pc_q[1], 32'h8); end
        checks++; if (pop_pc_q[2] !== 32'hC) begin errors++; $display("FAIL basic_pc3 got %h want %h", pop_pc_q[2], 32'hC); end
        checks++; if (pop_instr_q[2] !== instr_of(32'h8)) begin errors++; $display("FAIL basic_instr3 got %h want %h", pop_instr_q[2], instr_of(32'h8)); end
    endtask

    task automatic test_latency3();
        do_reset();
        lat = 3;
        StallF = 1'b0;
        repeat (20) cyc();
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc_cyc_q[i] - acc_cyc_q[i-1] !== 4) begin
                errors++; $display("FAIL lat3_req_gap%0d got %0d want 4", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
            end
            checks++;
            if (pop_cyc_q[i] - pop_cyc_q[i-1] !== 4) begin
                errors++; $display("FAIL lat3_pop_gap%0d got %0d want 4", i, pop_cyc_q[i] - pop_cyc_q[i-1]);
            end
        end
        checks++; if (pop_pc_q[3] !== 32'h10) begin errors++; $display("FAIL lat3_pc4 got %h want %h", pop_pc_q[3], 32'h10); end
`ifdef FETCH_PERF_EN
        checks++; if (BubbleCnt !== 32'd16) begin errors++; $display("FAIL lat3_bubblecnt got %0d want 16", BubbleCnt); end
`endif
    endtask

    task automatic test_stall_full();
        do_reset();
        lat = 1;
        StallD = 1'b1;
        StallF = 1'b0;
        repeat (6) cyc();
        StallD = 1'b0;
        cyc();
        StallD = 1'b1;
        cyc();
        cyc();
        StallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b want 0", i, imem_bus.imem_req); end
            checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL stall_pc%0d got %h want %h", i, PCPlus4D, 32'h4); end
            checks++; if (InstrD !== instr_of(32'h0)) begin errors++; $display("FAIL stall_instr%0d got %h want %h", i, InstrD, instr_of(32'h0)); end
        end
        StallF = 1'b0;
        StallD = 1'b0;
        repeat (12) cyc();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pop_pc_q[i] !== 32'(4 * (i + 1))) begin
                errors++; $display("FAIL stall_resume_pc%0d got %h want %h", i, pop_pc_q[i], 32'(4 * (i + 1)));
            end
            checks++;
            if (acc_q[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL stall_resume_addr%0d got %h want %h", i, acc_q[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        lat = 3;
        StallF = 1'b0;
        for (int i = 0; i < 40 && acc_q.size() == 0; i++) cyc();
        checks++; if (acc_q.size() == 0) begin errors++; $display("FAIL rdw_first_accept got none want 1"); end
        PCSrcD = 1'b1;
        FlushD = 1'b1;
        PCBranchD = 32'h100;
        cyc();
        PCSrcD = 1'b0;
        FlushD = 1'b0;
        #1;
        checks++; if (imem_bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rdw_addr got %h want %h", imem_bus.imem_addr, 32'h100); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req_kill got %b want 0", imem_bus.imem_req); end
        repeat (10) cyc();
        checks++; if (acc_q[1] !== 32'h100) begin errors++; $display("FAIL rdw_next_addr got %h want %h", acc_q[1], 32'h100); end
        checks++; if (pop_pc_q[0] !== 32'h104) begin errors++; $display("FAIL rdw_next_pc got %h want %h", pop_pc_q[0], 32'h104); end
        checks++; if (pop_instr_q[0] !== instr_of(32'h100)) begin errors++; $display("FAIL rdw_next_instr got %h want %h", pop_instr_q[0], instr_of(32'h100)); end
`ifdef FETCH_PERF_EN
        checks++; if (KillCnt !== 32'd1) begin errors++; $display("FAIL rdw_killcnt got %0d want 1", KillCnt); end
`endif
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        lat = 2;
        StallF = 1'b0;
        for (int i = 0; i < 40 && acc_q.size() == 0; i++) cyc();
        checks++; if (acc_q.size() == 0) begin errors++; $display("FAIL rdr_first_accept got none want 1"); end
        cyc();
        PCSrcD = 1'b1;
        FlushD = 1'b1;
        PCBranchD = 32'h200;
        cyc();
        PCSrcD = 1'b0;
        FlushD = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL rdr_req_idle got %b want 1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rdr_addr got %h want %h", imem_bus.imem_addr, 32'h200); end
        repeat (8) cyc();
        checks++; if (acc_q[1] !== 32'h200) begin errors++; $display("FAIL rdr_next_addr got %h want %h", acc_q[1], 32'h200); end
        checks++; if (pop_pc_q[0] !== 32'h204) begin errors++; $display("FAIL rdr_next_pc got %h want %h", pop_pc_q[0], 32'h204); end
`ifdef FETCH_PERF_EN
        checks++; if (KillCnt !== 32'd1) begin errors++; $display("FAIL rdr_killcnt got %0d want 1", KillCnt); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        lat = 5;
        StallF = 1'b0;
        cyc();
        StallF = 1'b1;
        reset = 1'b0;
        #1;
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rmw_valid got %b want 0", ValidD); end
        checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL rmw_instr got %h want 0", InstrD); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmw_req got %b want 0", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmw_addr got %h want 0", imem_bus.imem_addr); end
        cyc();
        cyc();
        reset = 1'b1;
        clear_logs();
        repeat (5) cyc();
        checks++; if (pop_pc_q.size() !== 0) begin errors++; $display("FAIL rmw_late_push got %0d pops want 0", pop_pc_q.size()); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rmw_late_valid got %b want 0", ValidD); end
        checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmw_late_addr got %h want 0", imem_bus.imem_addr); end
        lat = 1;
        StallF = 1'b0;
        repeat (6) cyc();
        checks++; if (acc_q[0] !== 32'h0) begin errors++; $display("FAIL rmw_resume_addr got %h want 0", acc_q[0]); end
        checks++; if (pop_pc_q[0] !== 32'h4) begin errors++; $display("FAIL rmw_resume_pc got %h want 4", pop_pc_q[0]); end
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        PCSrcD = 1'b1;
        FlushD = 1'b1;
        PCBranchD = 32'hFFFF_FFFC;
        StallF = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_req_redirect got %b want 0", imem_bus.imem_req); end
        cyc();
        PCSrcD = 1'b0;
        FlushD = 1'b0;
        repeat (8) cyc();
        checks++; if (acc_q[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h want %h", acc_q[0], 32'hFFFF_FFFC); end
        checks++; if (acc_q[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h want 0", acc_q[1]); end
        checks++; if (pop_pc_q[0] !== 32'h0) begin errors++; $display("FAIL wrap_pc0 got %h want 0", pop_pc_q[0]); end
        checks++; if (pop_instr_q[0] !== instr_of(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr0 got %h want %h", pop_instr_q[0], instr_of(32'hFFFF_FFFC)); end
        checks++; if (pop_pc_q[1] !== 32'h4) begin errors++; $display("FAIL wrap_pc1 got %h want 4", pop_pc_q[1]); end
    endtask

    task automatic test_ready_hold();
        do_reset();
        lat = 1;
        imem_bus.imem_ready = 1'b0;
        StallF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL ready_req%0d got %b want 1", i, imem_bus.imem_req); end
            checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ready_addr%0d got %h want 0", i, imem_bus.imem_addr); end
        end
        imem_bus.imem_ready = 1'b1;
        repeat (4) cyc();
        checks++; if (acc_q[0] !== 32'h0) begin errors++; $display("FAIL ready_accept got %h want 0", acc_q[0]); end
        checks++; if (pop_pc_q[0] !== 32'h4) begin errors++; $display("FAIL ready_pc got %h want 4", pop_pc_q[0]); end
    endtask

    initial begin
        reset = 1'b0;
        StallF = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b0;
        PCSrcD = 1'b0;
        PCBranchD = 32'h0;
        imem_bus.imem_ready  = 1'b1;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;
        test_reset();
        test_basic();
        test_latency3();
        test_stall_full();
        test_redirect_wait();
        test_redirect_rvalid();
        test_reset_mid_wait();
        test_wrap();
        test_ready_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage plus IF/ID register for the pipelined MIPS core; feeds decode (InstrD, PCPlus4D) and obeys the hazard unit (StallF, StallD, FlushD).
- Owns PCF and drives a single-outstanding-request instruction-memory handshake with variable latency.
- Buffers returned instructions in a small FIFO, so decode sees bubbles, not protocol timing.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- BUF_DEPTH, 2, fetch FIFO entries (≥1); occupancy plus outstanding request never exceeds it.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- StallF  in  1  hazard unit: hold PC, issue no new request
- StallD  in  1  hazard unit: hold IF/ID register
- FlushD  in  1  hazard unit: load bubble into IF/ID
- PCSrcD  in  1  branch/jump taken in decode
- PCBranchD  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (= PCF)
- imem_ready  in  1  request accepted when imem_req && imem_ready
- imem_rvalid  in  1  response valid, one cycle, in order
- imem_rdata  in  32  response instruction
- InstrD  out  32  decode instruction (32'h0 = NOP on bubble)
- PCPlus4D  out  32  PC+4 of InstrD
- ValidD  out  1  InstrD is real

Behaviour:
- Reset (async, reset=0): PCF=RESET_PC, state IDLE, FIFO empty, InstrD=0, PCPlus4D=0, ValidD=0, imem_req=0. A response arriving after reset (state IDLE) is ignored.
- FSM states: IDLE, WAIT, KILL.
  - IDLE: imem_req=1 iff !StallF && (count < BUF_DEPTH). On accept: latch addr, PCF<=PCF+4, go WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {imem_rdata, addr+4}, go IDLE. The next request is issued no earlier than the following cycle.
  - KILL: imem_req=0. On imem_rvalid: discard, go IDLE.
- IF/ID register update priority (when !StallD):
  - FlushD: bubble.
  - Else FIFO non-empty: pop head into InstrD/PCPlus4D, ValidD=1.
  - Else bubble (InstrD=0, ValidD=0).
- StallD=1: IF/ID holds, no pop, even if FlushD=1 (hazard unit never asserts both).
- Redirect (PCSrcD && !StallD):
  - PCF<=PCBranchD; FIFO cleared.
  - IDLE: no request that cycle. WAIT: go KILL. If rvalid lands in the same cycle, it is discarded and the FSM goes IDLE.
  - Redirect beats both push and pop. Hazard unit pairs it with FlushD.
- StallF only blocks new requests. An outstanding response is still accepted and pushed.
- Same-cycle push and pop when FIFO full is legal; count is unchanged.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. No misalignment checks; low 2 bits pass through.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs BubbleCnt[31:0] and KillCnt[31:0], both saturating at 32'hFFFF_FFFF and reset to 0.
  - BubbleCnt increments on each !StallD cycle where an empty FIFO forces a bubble (FlushD bubbles excluded).
  - KillCnt increments on each discarded response.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- mips_pkg: fetch_state_t enum {IDLE, WAIT, KILL}; fetch_entry_t struct {instr[31:0], pcplus4[31:0]}; NOP_INSTR = 32'h0.
- Sub-module fetch_fifo: parameterised by BUF_DEPTH, fetch_entry_t payload, push/pop/clear/full/empty/count, async active-low reset.

Test Plan:
- Reset, imem_ready=1, 1-cycle latency, StallD=0 -> first real InstrD has PCPlus4D=4; consecutive fetches have PCPlus4D 4, 8, 12; ValidD=0 until the first pop.
- 3-cycle latency -> imem_req pulses once per 4 cycles; ValidD=0 bubbles in between; BubbleCnt increments per bubble when FETCH_PERF_EN is defined.
- Hold StallF=StallD=1 for 5 cycles with FIFO full -> imem_req=0; InstrD/PCPlus4D unchanged; after release, resume without skipped or duplicated PC.
- In WAIT, PCSrcD=1, PCBranchD=32'h100, FlushD=1 -> stale response discarded (KillCnt=1); next imem_addr=32'h100; next real PCPlus4D=32'h104.
- Redirect in the same cycle as imem_rvalid -> response dropped, FSM goes IDLE, next request goes to the target.
- Assert reset=0 mid-WAIT, release after 2 cycles -> outputs at reset values; imem_addr=RESET_PC; late rvalid ignored.
